add: RTL and testbench

ADD -- requirements
Module: add

---
 rtl/add_pkg.sv | 12 +
 rtl/add_if.sv | 29 ++
 rtl/add_skid_buf.sv | 124 ++++++++++++
 rtl/add.sv | 46 ++++
 tb/tb_add.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the add block: buffer occupancy encoding and default width.
package add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/add_if.sv
// Operand/result ready-valid bundle. The master drives operands and out_ready; the slave is the adder.
interface add_if
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_cout;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_a, in_b, in_cin, in_valid, out_ready,
    input  in_ready, out, out_cout, out_ovf, out_valid
  );

  modport slave (
    input  in_a, in_b, in_cin, in_valid, out_ready,
    output in_ready, out, out_cout, out_ovf, out_valid
  );

endinterface

// File: rtl/add_skid_buf.sv
// Ready/valid output buffer: one head entry plus an optional skid entry that catches the
// transfer already in flight when the consumer stalls.
module add_skid_buf
  import add_pkg::*;
#(
  parameter int DW   = 34,
  parameter int SKID = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  occ_t          state_reg;
  occ_t          state_next;
  logic [DW-1:0] head_reg;
  logic [DW-1:0] skid_reg;
  logic          push;
  logic          pop;
  logic          load_head;
  logic          load_skid;
  logic          head_from_skid;

  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_next = (SKID != 0) ? TWO : ONE;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists
        if (pop) begin
          state_next     = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_head) begin
        head_reg <= head_from_skid ? skid_reg : in_data;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_reg_ready
      logic rdy_reg;

      // Low through reset; first edge afterwards raises it since next state cannot be TWO
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdy_reg <= 1'b0;
        end else begin
          rdy_reg <= (state_next != TWO);
        end
      end
      assign in_ready = rdy_reg;
    end else begin : g_comb_ready
      logic live_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          live_reg <= 1'b0;
        end else begin
          live_reg <= 1'b1;
        end
      end
      assign in_ready = live_reg && (!out_valid || out_ready);
    end
  endgenerate

  // Stale head contents never leak out while nothing is valid
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_mask
      assign out_data[gi] = head_reg[gi] & out_valid;
    end
  endgenerate

endmodule

// File: rtl/add.sv
// Registered adder: WIDTH-bit sum with unsigned carry-out and signed overflow, delivered
// through a ready/valid output buffer.
module add
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SKID  = 1
) (
  input logic   clk,
  input logic   rst,
  add_if.slave  bus
);

  logic [WIDTH:0]   sum_full;
  logic             ovf;
  logic [WIDTH+1:0] res_in;
  logic [WIDTH+1:0] res_out;

  always_comb begin
    sum_full = {1'b0, bus.in_a} + {1'b0, bus.in_b} + (WIDTH+1)'(bus.in_cin);
    ovf      = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
               (sum_full[WIDTH-1] != bus.in_a[WIDTH-1]);
  end

  // Buffer word layout: {cout, ovf, sum}
  assign res_in = {sum_full[WIDTH], ovf, sum_full[WIDTH-1:0]};

  add_skid_buf #(
    .DW   (WIDTH + 2),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (res_in),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (res_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.out      = res_out[WIDTH-1:0];
  assign bus.out_ovf  = res_out[WIDTH];
  assign bus.out_cout = res_out[WIDTH+1];

endmodule

// File: tb/tb_add.sv
// Directed bench for add (WIDTH=32, SKID=1): reset, single adds, stalled stream, reset with full buffer.
module tb_add;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  add_if #(.WIDTH(W)) bus ();

  add #(.WIDTH(W), .SKID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] vec_a [0:7] = '{32'h0000_0001, 32'h0000_0010, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h1234_5678, 32'h4000_0000, 32'hDEAD_BEEF, 32'h8000_0000};
  logic [31:0] vec_b [0:7] = '{32'h0000_0002, 32'h0000_0020, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h1111_1111, 32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
  logic        vec_c [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] exp_s [0:7] = '{32'h0000_0003, 32'h0000_0031, 32'h0000_0000, 32'hFFFF_FFFF,
                               32'h2345_6789, 32'h8000_0000, 32'hDEAD_BEF0, 32'h0000_0000};
  logic        exp_c [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        exp_o [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic v);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    bus.in_valid = v;
  endtask

  task automatic check_result(input string tag, input logic [31:0] s, input logic co, input logic ov);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_sum"},   64'(bus.out),       64'(s));
    check({tag, "_cout"},  64'(bus.out_cout),  64'(co));
    check({tag, "_ovf"},   64'(bus.out_ovf),   64'(ov));
    $display("result %s: out=0x%08h cout=%0b ovf=%0b", tag, bus.out, bus.out_cout, bus.out_ovf);
  endtask

  int          tx;
  int          rx;
  int          accepted;
  int          seen;
  logic        prev_stall;
  logic [33:0] held;

  initial begin
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state, no clock edge yet
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out",       64'(bus.out),       64'd0);
    check("rst_cout",      64'(bus.out_cout),  64'd0);
    check("rst_ovf",       64'(bus.out_ovf),   64'd0);

    // Release with operands already valid: the first edge must not accept them
    @(negedge clk);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    check("rel_in_ready_pre", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rel_in_ready_post", 64'(bus.in_ready),  64'd1);
    check("rel_no_accept",     64'(bus.out_valid), 64'd0);

    // Three back-to-back adds, each result due one cycle after its transfer
    @(negedge clk);
    check_result("add_5_3", 32'h0000_0008, 1'b0, 1'b0);
    check("b2b_in_ready1", 64'(bus.in_ready), 64'd1);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    check_result("add_wrap", 32'h0000_0000, 1'b1, 1'b0);
    check("b2b_in_ready2", 64'(bus.in_ready), 64'd1);
    drive(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    @(negedge clk);
    check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_out",   64'(bus.out),       64'd0);
    check("idle_cout",  64'(bus.out_cout),  64'd0);
    check("idle_ovf",   64'(bus.out_ovf),   64'd0);

    // Stream of 8 with out_ready cycling 1,0,0,1
    tx         = 0;
    rx         = 0;
    prev_stall = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_hold",  64'({bus.out_cout, bus.out_ovf, bus.out}), 64'(held));
      end
      bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (tx < 8) drive(vec_a[tx], vec_b[tx], vec_c[tx], 1'b1);
      else        drive(32'h0, 32'h0, 1'b0, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        check_result($sformatf("stream%0d", rx), exp_s[rx], exp_c[rx], exp_o[rx]);
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      prev_stall = bus.out_valid && !bus.out_ready;
      held       = {bus.out_cout, bus.out_ovf, bus.out};
    end
    check("stream_count", 64'(rx), 64'd8);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stream_drained", 64'(bus.out_valid), 64'd0);

    // Consumer stalled: exactly two operands accepted, then in_ready drops
    bus.out_ready = 1'b0;
    accepted      = 0;
    for (int k = 0; k < 5; k++) begin
      drive(vec_a[k], vec_b[k], vec_c[k], 1'b1);
      if (bus.in_ready) accepted++;
      @(negedge clk);
    end
    $display("stall fill: accepted=%0d", accepted);
    check("fill_accepted", 64'(accepted),      64'd2);
    check("fill_in_ready", 64'(bus.in_ready),  64'd0);
    check("fill_head",     64'(bus.out),       64'(exp_s[0]));

    // Asynchronous reset mid-cycle with two results held
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd0);
    check("arst_out",       64'(bus.out),       64'd0);
    check("arst_cout",      64'(bus.out_cout),  64'd0);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    seen          = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    $display("post-reset drain: results seen=%0d", seen);
    check("arst_nothing_out", 64'(seen),         64'd0);
    check("arst_ready_back",  64'(bus.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
